// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory access controller.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE,
        ST_RESP
    } state_e;

    // Big-endian: byte offset 0 lives in the top lane, so the shift shrinks as the offset grows.
    function automatic logic [4:0] lane_shift(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_shift = {~off, 3'b000};
            SZ_HALF: lane_shift = {~off[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input size_e size);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                               input size_e size, input logic [1:0] off);
        logic [4:0]  sh;
        logic [31:0] m;
        sh = lane_shift(size, off);
        m  = lane_mask(size);
        lane_merge = (word & ~(m << sh)) | ((data & m) << sh);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] off);
        lane_extract = (word >> lane_shift(size, off)) & lane_mask(size);
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Merges store data into a memory word and extracts right-justified load data from it.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  off,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    assign merged    = lane_merge(word, wdata, size, off);
    assign extracted = lane_extract(word, size, off);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-master arbiter/sequencer for the word-wide big-endian data memory (define DMEM_ARB_RR_EN for round-robin).
// Latency from handshake: error +1, load/word store +2, sub-word store +3 (read-modify-write).
// Backpressure: requests accepted only in IDLE; responses are single-cycle pulses with no back-pressure.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEMORY_SIZE = 16
)
(
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_write,
    input  logic [1:0]  m0_req_size,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_write,
    input  logic [1:0]  m1_req_size,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(MEMORY_SIZE - 4);

    state_e      state;
    logic        lat_mst;
    logic        lat_write;
    size_e       lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] cap_word;

    logic        gnt1;
    logic        hs;
    logic        sel_write;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        req_err;

    logic [31:0] lm_word;
    logic [31:0] lm_merged;
    logic [31:0] lm_extracted;

    logic        rsp_fire;
    logic        rsp_m1;
    logic [31:0] rsp_rd;
    logic        rsp_er;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;
    assign gnt1 = m1_req_valid & (~m0_req_valid | rr_ptr);
`else
    assign gnt1 = m1_req_valid & ~m0_req_valid;
`endif

    assign m0_req_ready = (state == ST_IDLE) & m0_req_valid & ~gnt1;
    assign m1_req_ready = (state == ST_IDLE) & gnt1;
    assign hs           = (m0_req_valid & m0_req_ready) | (m1_req_valid & m1_req_ready);

    assign sel_write = gnt1 ? m1_req_write : m0_req_write;
    assign sel_size  = gnt1 ? m1_req_size  : m0_req_size;
    assign sel_addr  = gnt1 ? m1_req_addr  : m0_req_addr;
    assign sel_wdata = gnt1 ? m1_req_wdata : m0_req_wdata;

    always_comb begin
        req_err = 1'b0;
        case (size_e'(sel_size))
            SZ_HALF: req_err = sel_addr[0];
            SZ_WORD: req_err = |sel_addr[1:0];
            SZ_ILL:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({sel_addr[31:2], 2'b00} > LAST_WORD)
            req_err = 1'b1;
    end

    // MERGE rewrites the word captured in ACCESS; every other state works on the live read data.
    assign lm_word = (state == ST_MERGE) ? cap_word : mem_rdata;

    dmem_lane_merge u_lane (
        .word      (lm_word),
        .wdata     (lat_wdata),
        .size      (lat_size),
        .off       (lat_addr[1:0]),
        .merged    (lm_merged),
        .extracted (lm_extracted)
    );

    assign mem_addr  = {lat_addr[31:2], 2'b00};
    assign mem_wdata = lm_merged;
    assign mem_write = ((state == ST_ACCESS) & lat_write & (lat_size == SZ_WORD))
                     | (state == ST_MERGE);

    always_comb begin
        rsp_fire = 1'b0;
        rsp_m1   = lat_mst;
        rsp_rd   = '0;
        rsp_er   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs && req_err) begin
                    rsp_fire = 1'b1;
                    rsp_m1   = gnt1;
                    rsp_er   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!lat_write) begin
                    rsp_fire = 1'b1;
                    rsp_rd   = lm_extracted;
                end else if (lat_size == SZ_WORD) begin
                    rsp_fire = 1'b1;
                end
            end
            ST_MERGE: rsp_fire = 1'b1;
            default:  rsp_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lat_mst      <= 1'b0;
            lat_write    <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cap_word     <= '0;
            m0_rsp_valid <= 1'b0;
            m0_rsp_rdata <= '0;
            m0_rsp_err   <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_rdata <= '0;
            m1_rsp_err   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr       <= 1'b0;
`endif
        end else begin
            m0_rsp_valid <= rsp_fire & ~rsp_m1;
            m0_rsp_rdata <= (rsp_fire & ~rsp_m1) ? rsp_rd : '0;
            m0_rsp_err   <= rsp_fire & ~rsp_m1 & rsp_er;
            m1_rsp_valid <= rsp_fire & rsp_m1;
            m1_rsp_rdata <= (rsp_fire & rsp_m1) ? rsp_rd : '0;
            m1_rsp_err   <= rsp_fire & rsp_m1 & rsp_er;

            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        lat_mst   <= gnt1;
                        lat_write <= sel_write;
                        lat_size  <= size_e'(sel_size);
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= req_err ? ST_RESP : ST_ACCESS;
`ifdef DMEM_ARB_RR_EN
                        rr_ptr    <= ~rr_ptr;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (lat_write && lat_size != SZ_WORD) begin
                        cap_word <= mem_rdata;
                        state    <= ST_MERGE;
                    end else begin
                        state    <= ST_RESP;
                    end
                end
                ST_MERGE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 16-byte behavioural memory.
// Latency, data and error responses are compared against hand-computed values.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        m0_req_valid = 1'b0, m0_req_ready, m0_req_write = 1'b0;
    logic [1:0]  m0_req_size = 2'b00;
    logic [31:0] m0_req_addr = '0, m0_req_wdata = '0;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;

    logic        m1_req_valid = 1'b0, m1_req_ready, m1_req_write = 1'b0;
    logic [1:0]  m1_req_size = 2'b00;
    logic [31:0] m1_req_addr = '0, m1_req_wdata = '0;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;

    logic [31:0] mem [4];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rsp_cnt0 = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEMORY_SIZE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_write (m0_req_write),
        .m0_req_size  (m0_req_size),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_write (m1_req_write),
        .m1_req_size  (m1_req_size),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[3:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_addr[3:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge clk)
        if (m0_rsp_valid) rsp_cnt0 <= rsp_cnt0 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic v, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_req_valid = v; m0_req_write = w; m0_req_size = sz; m0_req_addr = a; m0_req_wdata = d;
        end else begin
            m1_req_valid = v; m1_req_write = w; m1_req_size = sz; m1_req_addr = a; m1_req_wdata = d;
        end
    endtask

    // Latency is counted so that the handshake edge ends cycle T and a response visible in cycle T+k gives k.
    task automatic do_req(input int m, input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
        int  e;
        bit  got;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        e   = 0;
        @(negedge clk);
        drive(m, 1'b1, w, sz, a, d);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if ((m == 0) ? m0_req_ready : m1_req_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            drive(m, 1'b0, 1'b0, 2'b00, '0, '0);
            chk("hs_timeout", 32'd0, 32'd1);
            return;
        end
        e = cyc + 1;
        @(posedge clk);
        #1;
        drive(m, 1'b0, 1'b0, 2'b00, '0, '0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_rsp_valid : m1_rsp_valid) begin
                got = 1;
                lat = cyc - e + 1;
                rd  = (m == 0) ? m0_rsp_rdata : m1_rsp_rdata;
                er  = (m == 0) ? m0_rsp_err : m1_rsp_err;
                break;
            end
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w0;
    int          c0;
    int          grants [4];
    int          ng;
    bit          reached;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_m0_ready", 32'(m0_req_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_req_ready), 32'd0);
        chk("rst_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_rdata0", m0_rsp_rdata, 32'd0);
        chk("rst_err", {30'd0, m1_rsp_err, m0_rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_req(0, 1'b1, 2'b10, 32'd4, 32'hDEADBEEF, rd, er, lat);
        chk("wst_lat", 32'(lat), 32'd2);
        chk("wst_err", 32'(er), 32'd0);
        chk("wst_mem", mem[1], 32'hDEADBEEF);

        do_req(0, 1'b0, 2'b10, 32'd4, '0, rd, er, lat);
        chk("wld_lat", 32'(lat), 32'd2);
        chk("wld_rdata", rd, 32'hDEADBEEF);
        chk("wld_err", 32'(er), 32'd0);

        do_req(1, 1'b1, 2'b00, 32'd5, 32'h0000_0011, rd, er, lat);
        chk("bst_lat", 32'(lat), 32'd3);
        chk("bst_rdata", rd, 32'd0);
        chk("bst_mem", mem[1], 32'hDE11BEEF);

        do_req(1, 1'b0, 2'b00, 32'd5, '0, rd, er, lat);
        chk("bld_rdata", rd, 32'h0000_0011);
        chk("bld_lat", 32'(lat), 32'd2);

        w0 = wr_cnt;
        do_req(0, 1'b0, 2'b01, 32'd3, '0, rd, er, lat);
        chk("hmis_err", 32'(er), 32'd1);
        chk("hmis_lat", 32'(lat), 32'd1);
        chk("hmis_rdata", rd, 32'd0);
        chk("hmis_nowrite", 32'(wr_cnt - w0), 32'd0);

        do_req(0, 1'b0, 2'b10, 32'd16, '0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        w0 = wr_cnt;
        do_req(1, 1'b1, 2'b11, 32'd0, 32'h5555_5555, rd, er, lat);
        chk("ill_err", 32'(er), 32'd1);
        chk("ill_nowrite", 32'(wr_cnt - w0), 32'd0);

        do_req(1, 1'b1, 2'b10, 32'd12, 32'hA5A5_0F0F, rd, er, lat);
        chk("last_err", 32'(er), 32'd0);
        chk("last_mem", mem[3], 32'hA5A5_0F0F);
        do_req(0, 1'b0, 2'b01, 32'd14, '0, rd, er, lat);
        chk("hld14_rdata", rd, 32'h0000_0F0F);

        do_req(0, 1'b1, 2'b10, 32'd0, 32'h1234_5678, rd, er, lat);
        chk("w0_mem", mem[0], 32'h1234_5678);

        // Abort a half store in its write cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b01, 32'd2, 32'h0000_ABCD);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 2'b00, '0, '0);
        c0 = rsp_cnt0;
        reached = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write) begin
                reached = 1;
                break;
            end
        end
        chk("merge_reached", 32'(reached), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_cnt0 - c0), 32'd0);
        chk("abort_mem", mem[0], 32'h1234_5678);

        do_req(0, 1'b1, 2'b01, 32'd2, 32'h0000_CAFE, rd, er, lat);
        chk("hst_lat", 32'(lat), 32'd3);
        chk("hst_mem", mem[0], 32'h1234_CAFE);
        do_req(1, 1'b0, 2'b00, 32'd0, '0, rd, er, lat);
        chk("bld0_rdata", rd, 32'h0000_0012);
        do_req(1, 1'b0, 2'b01, 32'd0, '0, rd, er, lat);
        chk("hld0_rdata", rd, 32'h0000_1234);

        apply_reset();
        drive(0, 1'b1, 1'b0, 2'b10, 32'd0, '0);
        drive(1, 1'b1, 1'b0, 2'b10, 32'd4, '0);
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (m0_req_ready) begin
                grants[ng] = 0;
                ng++;
            end else if (m1_req_ready) begin
                grants[ng] = 1;
                ng++;
            end
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1, 1'b0, 1'b0, 2'b00, '0, '0);
        chk("arb_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
`ifdef DMEM_ARB_RR_EN
            chk($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));
`else
            chk($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'd0);
`endif
        end
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
